// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Purpose : shared integer-pipeline types used by the register file and its
//           scoreboard bank.
// Contents: reg_idx_t  - architectural register index (x0..x31)
//           tag_t      - producer tag carried from issue to writeback
//           REG_ZERO   - index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package rv32i_types;

    typedef logic [4:0] reg_idx_t;
    typedef logic [3:0] tag_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_sb_bank.sv
// ---------------------------------------------------------------------------
// regfile_sb_bank
// Purpose : busy/tag scoreboard for the multi-port register file.  Each
//           register holds a busy bit plus the tag of the producer that
//           reserved it.  A writeback clears busy only when its tag matches,
//           so stale producers cannot release a newer reservation.
// Ports   : clk, rst            clock / async active-high reset
//           we, rd_s, rd_tag    writeback ports (enable, index, tag)
//           rs_s                read-port indices
//           mark_en/s/tag       reservation at issue
//           flush               clear every busy bit (tags are kept)
//           rs_busy             per-read-port busy (combinational)
// ---------------------------------------------------------------------------
module regfile_sb_bank
    import rv32i_types::*;
#(
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int TAGW   = 4,
    parameter int BYPASS = 1,
    parameter int IDXW   = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][IDXW-1:0]   rd_s,
    input  logic [NWR-1:0][TAGW-1:0]   rd_tag,
    input  logic [NRD-1:0][IDXW-1:0]   rs_s,
    input  logic                       mark_en,
    input  logic [IDXW-1:0]            mark_s,
    input  logic [TAGW-1:0]            mark_tag,
    input  logic                       flush,
    output logic [NRD-1:0]             rs_busy
);

    localparam logic [IDXW-1:0] ZERO_IDX = IDXW'(REG_ZERO);

    logic [NREG-1:0]           busy_q, busy_d;
    logic [NREG-1:0][TAGW-1:0] tag_q, tag_d;

    // Next scoreboard state.  Tag-matching writebacks clear first, compared
    // against the registered tag so a reservation made this same cycle is
    // never cleared by the older producer.  Then flush wipes all busy bits
    // (and swallows any mark); otherwise a mark sets busy and the new tag,
    // overriding a clear on the same register because the new producer is
    // younger.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int i = 0; i < NWR; i++) begin
            if (we[i] && rd_s[i] != ZERO_IDX && busy_q[rd_s[i]] &&
                tag_q[rd_s[i]] == rd_tag[i]) begin
                busy_d[rd_s[i]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (mark_en && mark_s != ZERO_IDX) begin
            busy_d[mark_s] = 1'b1;
            tag_d[mark_s]  = mark_tag;
        end
    end

    // Scoreboard registers; reset clears busy bits and tags immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    // Read-side busy.  x0 is never busy.  With bypass, a writeback this
    // cycle whose tag matches the current owner releases the source early;
    // a mark in flight never shows up here until after the edge.
    always_comb begin
        rs_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rs_s[p] != ZERO_IDX) begin
                rs_busy[p] = busy_q[rs_s[p]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (we[i] && rd_s[i] == rs_s[p] &&
                            tag_q[rs_s[p]] == rd_tag[i]) begin
                            rs_busy[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
// Purpose : multi-port integer register file (NRD read, NWR write) with an
//           integrated tagged scoreboard.  x0 always reads zero and is never
//           busy.  Optional same-cycle write->read bypass of data and of
//           busy release.
// Ports   : clk, rst                  clock / async active-high reset
//           we, rd_s, rd_v, rd_tag    writeback ports (higher index = younger)
//           rs_s, rs_v, rs_busy       read ports (combinational outputs)
//           mark_en, mark_s, mark_tag reservation of a destination at issue
//           flush                     squash: clear all busy bits
// ---------------------------------------------------------------------------
module regfile_mp_sb
    import rv32i_types::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int TAGW   = 4,
    parameter int BYPASS = 1,
    parameter int IDXW   = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][IDXW-1:0]   rd_s,
    input  logic [NWR-1:0][XLEN-1:0]   rd_v,
    input  logic [NWR-1:0][TAGW-1:0]   rd_tag,
    input  logic [NRD-1:0][IDXW-1:0]   rs_s,
    output logic [NRD-1:0][XLEN-1:0]   rs_v,
    output logic [NRD-1:0]             rs_busy,
    input  logic                       mark_en,
    input  logic [IDXW-1:0]            mark_s,
    input  logic [TAGW-1:0]            mark_tag,
    input  logic                       flush
);

    localparam logic [IDXW-1:0] ZERO_IDX = IDXW'(REG_ZERO);

    logic [NREG-1:0][XLEN-1:0] regs_q;

    // Data array.  Ports are walked in ascending order so the last
    // non-blocking assignment (the youngest port) wins on a collision.
    // Writes to x0 are dropped, so regs_q[0] stays at its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && rd_s[i] != ZERO_IDX) begin
                    regs_q[rd_s[i]] <= rd_v[i];
                end
            end
        end
    end

    // Read muxes.  Outputs are forced to zero while reset is held so the
    // bypass path cannot leak in-flight write data.  With bypass, the
    // youngest matching write port overrides the stored value.
    always_comb begin
        rs_v = '0;
        for (int p = 0; p < NRD; p++) begin
            if (!rst && rs_s[p] != ZERO_IDX) begin
                rs_v[p] = regs_q[rs_s[p]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (we[i] && rd_s[i] == rs_s[p]) begin
                            rs_v[p] = rd_v[i];
                        end
                    end
                end
            end
        end
    end

    regfile_sb_bank #(
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .TAGW   (TAGW),
        .BYPASS (BYPASS),
        .IDXW   (IDXW)
    ) u_sb_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .rd_s     (rd_s),
        .rd_tag   (rd_tag),
        .rs_s     (rs_s),
        .mark_en  (mark_en),
        .mark_s   (mark_s),
        .mark_tag (mark_tag),
        .flush    (flush),
        .rs_busy  (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and
// compares both against an array-based reference model of the register
// file and scoreboard.  Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       we;
    logic [1:0][4:0]  rd_s;
    logic [1:0][31:0] rd_v;
    logic [1:0][3:0]  rd_tag;
    logic [3:0][4:0]  rs_s;
    logic             mark_en;
    logic [4:0]       mark_s;
    logic [3:0]       mark_tag;
    logic             flush;

    logic [3:0][31:0] rs_v1, rs_v0;
    logic [3:0]       rs_busy1, rs_busy0;

    // Reference state: plain arrays indexed by register number.
    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .we(we), .rd_s(rd_s), .rd_v(rd_v),
        .rd_tag(rd_tag), .rs_s(rs_s), .rs_v(rs_v1), .rs_busy(rs_busy1),
        .mark_en(mark_en), .mark_s(mark_s), .mark_tag(mark_tag), .flush(flush)
    );

    regfile_mp_sb #(.BYPASS(0)) dut_reg (
        .clk(clk), .rst(rst), .we(we), .rd_s(rd_s), .rd_v(rd_v),
        .rd_tag(rd_tag), .rs_s(rs_s), .rs_v(rs_v0), .rs_busy(rs_busy0),
        .mark_en(mark_en), .mark_s(mark_s), .mark_tag(mark_tag), .flush(flush)
    );

    // Expected read data: zero in reset or for x0; with bypass the youngest
    // (highest-index) enabled write to the same register supplies the value.
    function automatic logic [31:0] expV(int p, bit byp);
        logic [4:0] r;
        r = rs_s[p];
        if (rst || r == 5'd0) return 32'd0;
        if (byp) begin
            for (int i = 1; i >= 0; i--) begin
                if (we[i] && rd_s[i] == r) return rd_v[i];
            end
        end
        return m_data[r];
    endfunction

    // Expected busy: registered bit, released early by a tag-matching
    // writeback only when bypass is enabled.
    function automatic logic expBusy(int p, bit byp);
        logic [4:0] r;
        r = rs_s[p];
        if (rst || r == 5'd0 || !m_busy[r]) return 1'b0;
        if (byp) begin
            for (int i = 0; i < 2; i++) begin
                if (we[i] && rd_s[i] == r && rd_tag[i] == m_tag[r]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] obs,
                              input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int p = 0; p < 4; p++) begin
            checkValue($sformatf("byp.rs_v[%0d] x%0d", p, rs_s[p]), rs_v1[p], expV(p, 1'b1));
            checkValue($sformatf("reg.rs_v[%0d] x%0d", p, rs_s[p]), rs_v0[p], expV(p, 1'b0));
            checkValue($sformatf("byp.rs_busy[%0d] x%0d", p, rs_s[p]),
                       {31'd0, rs_busy1[p]}, {31'd0, expBusy(p, 1'b1)});
            checkValue($sformatf("reg.rs_busy[%0d] x%0d", p, rs_s[p]),
                       {31'd0, rs_busy0[p]}, {31'd0, expBusy(p, 1'b0)});
        end
    endtask

    // Advance the reference model across one rising edge.
    task automatic modelUpdate();
        logic       old_busy [32];
        logic [3:0] old_tag  [32];
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            return;
        end
        old_busy = m_busy;
        old_tag  = m_tag;
        for (int i = 0; i < 2; i++) begin
            if (we[i] && rd_s[i] != 5'd0) begin
                m_data[rd_s[i]] = rd_v[i];
                if (old_busy[rd_s[i]] && old_tag[rd_s[i]] == rd_tag[i])
                    m_busy[rd_s[i]] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else if (mark_en && mark_s != 5'd0) begin
            m_busy[mark_s] = 1'b1;
            m_tag[mark_s]  = mark_tag;
        end
    endtask

    // One clock of the currently driven inputs: compare outputs, take the
    // edge, update the model, return at the next falling edge with the
    // one-shot controls cleared.
    task automatic applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        we = '0; mark_en = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [4:0] randIdx();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        rst = 1'b1; we = '0; rd_s = '0; rd_v = '0; rd_tag = '0; rs_s = '0;
        mark_en = 1'b0; mark_s = '0; mark_tag = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rs_s = {5'd3, 5'd2, 5'd1, 5'd0};
        #1;
        checkValue("reset rs_v[1]", rs_v1[1], 32'd0);
        checkValue("reset rs_busy", {28'd0, rs_busy1}, 32'd0);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // Write-port collision on x3: youngest port wins.
        we = 2'b11; rd_s = {5'd3, 5'd3}; rd_v = {32'h22, 32'h11};
        rs_s = {5'd0, 5'd0, 5'd0, 5'd3};
        #1;
        checkValue("collision bypass same cycle", rs_v1[0], 32'h22);
        checkValue("collision no-bypass old value", rs_v0[0], 32'h0);
        applyStimulus();
        #1;
        checkValue("collision no-bypass next cycle", rs_v0[0], 32'h22);

        // x0 is hardwired: writes dropped, marks ignored.
        we = 2'b01; rd_s = {5'd0, 5'd0}; rd_v = {32'h0, 32'hFFFF_FFFF};
        mark_en = 1'b1; mark_s = 5'd0; mark_tag = 4'd6;
        rs_s = {5'd0, 5'd0, 5'd0, 5'd0};
        applyStimulus();
        applyStimulus();
        checkValue("x0 read after write", rs_v1[0], 32'd0);
        checkValue("x0 busy after mark", {31'd0, rs_busy1[0]}, 32'd0);

        // Tag-qualified clear on x7.
        rs_s = {5'd0, 5'd0, 5'd0, 5'd7};
        mark_en = 1'b1; mark_s = 5'd7; mark_tag = 4'd3;
        applyStimulus();
        we = 2'b01; rd_s = {5'd0, 5'd7}; rd_v = {32'h0, 32'hA5A5_0001}; rd_tag = {4'd0, 4'd2};
        applyStimulus();
        #1;
        checkValue("x7 stale tag keeps busy", {31'd0, rs_busy0[0]}, 32'd1);
        checkValue("x7 stale tag data", rs_v0[0], 32'hA5A5_0001);
        we = 2'b10; rd_s = {5'd7, 5'd0}; rd_v = {32'hA5A5_0002, 32'h0}; rd_tag = {4'd3, 4'd0};
        applyStimulus();
        #1;
        checkValue("x7 matching tag clears", {31'd0, rs_busy0[0]}, 32'd0);
        checkValue("x7 matching tag data", rs_v0[0], 32'hA5A5_0002);

        // Mark beats a same-cycle clear on x9.
        rs_s = {5'd0, 5'd0, 5'd0, 5'd9};
        mark_en = 1'b1; mark_s = 5'd9; mark_tag = 4'd4;
        applyStimulus();
        mark_en = 1'b1; mark_s = 5'd9; mark_tag = 4'd5;
        we = 2'b01; rd_s = {5'd0, 5'd9}; rd_v = {32'h0, 32'h99}; rd_tag = {4'd0, 4'd4};
        applyStimulus();
        we = 2'b01; rd_s = {5'd0, 5'd9}; rd_v = {32'h0, 32'h9A}; rd_tag = {4'd0, 4'd4};
        #1;
        checkValue("x9 old tag no longer owns", {31'd0, rs_busy1[0]}, 32'd1);
        applyStimulus();
        we = 2'b01; rd_s = {5'd0, 5'd9}; rd_v = {32'h0, 32'h9B}; rd_tag = {4'd0, 4'd5};
        #1;
        checkValue("x9 new tag 5 releases", {31'd0, rs_busy1[0]}, 32'd0);
        applyStimulus();

        // Flush with every register busy, plus a mark and a write that cycle.
        for (int r = 1; r < 32; r++) begin
            mark_en = 1'b1; mark_s = 5'(r); mark_tag = 4'(r);
            applyStimulus();
        end
        rs_s = {5'd31, 5'd1, 5'd10, 5'd4};
        flush = 1'b1; mark_en = 1'b1; mark_s = 5'd4; mark_tag = 4'd9;
        we = 2'b01; rd_s = {5'd0, 5'd10}; rd_v = {32'h0, 32'h600D}; rd_tag = {4'd0, 4'd1};
        applyStimulus();
        #1;
        checkValue("flush clears all busy", {28'd0, rs_busy0}, 32'd0);
        checkValue("flush coincident write", rs_v0[1], 32'h600D);
        applyStimulus();

        // Reset mid-run with x5 holding data and busy; in-flight write lost.
        rs_s = {5'd0, 5'd0, 5'd0, 5'd5};
        we = 2'b01; rd_s = {5'd0, 5'd5}; rd_v = {32'h0, 32'hDEAD_BEEF};
        mark_en = 1'b1; mark_s = 5'd5; mark_tag = 4'd1;
        applyStimulus();
        rst = 1'b1;
        we = 2'b01; rd_s = {5'd0, 5'd5}; rd_v = {32'h0, 32'h1234_5678};
        applyStimulus();
        rst = 1'b0;
        #1;
        checkValue("x5 after reset data", rs_v0[0], 32'd0);
        checkValue("x5 after reset busy", {31'd0, rs_busy0[0]}, 32'd0);
        applyStimulus();

        // Random traffic, small tag range so matches and collisions happen.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                we[i]     = ($urandom_range(0, 2) != 0);
                rd_s[i]   = randIdx();
                rd_v[i]   = $urandom;
                rd_tag[i] = 4'($urandom_range(0, 3));
            end
            for (int p = 0; p < 4; p++) rs_s[p] = randIdx();
            mark_en  = ($urandom_range(0, 1) == 0);
            mark_s   = randIdx();
            mark_tag = 4'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 15) == 0);
            applyStimulus();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
